// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter
//  Purpose  : Round-robin arbiter and three-state access sequencer that lets
//             two requesters share the single-ported data_memory block.
//             Requester 0 is the pipeline MEM stage and requester 1 is the
//             debug/loader port.
//  Ports    : clk, rst_n              - clock, async active-low reset
//             req*/we*/addr*/wdata*   - request inputs, sampled in IDLE only
//             gnt*, rvalid*, rdata*,  - per-requester responses
//             err*
//             busy                    - FSM is not IDLE
//             mem_read/mem_write/     - data_memory control, address,
//             mem_addr/mem_wdata/     - write data and combinational read data
//             mem_rdata
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              err0,
    output logic              err1,
    output logic              busy,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              sel_q, sel_d;
    logic              last_gnt_q, last_gnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic w_win;
    logic w_mis;
    logic w_access;
    logic w_resp;

    // Requester 1 wins when it is alone, or on a tie when requester 0 had
    // the previous grant.
    assign w_win    = req1 & (~req0 | ~last_gnt_q);
    assign w_mis    = |addr_q[2:0];
    assign w_access = (state_q == ST_ACCESS);
    assign w_resp   = (state_q == ST_RESP);

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        last_gnt_d = last_gnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req0 | req1) begin
                    sel_d   = w_win;
                    we_d    = w_win ? we1    : we0;
                    addr_d  = w_win ? addr1  : addr0;
                    wdata_d = w_win ? wdata1 : wdata0;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // Writes and errored accesses report zero read data.
                rdata_d = (~we_q & ~w_mis) ? mem_rdata : '0;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                last_gnt_d = sel_q;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            sel_q      <= 1'b0;
            last_gnt_q <= 1'b1;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            last_gnt_q <= last_gnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
        end
    end

    // All outputs decode from state and registers only, so the async reset
    // clears them immediately.
    assign mem_read  = w_access & ~w_mis & ~we_q;
    assign mem_write = w_access & ~w_mis &  we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign gnt0    = w_access & ~sel_q;
    assign gnt1    = w_access &  sel_q;
    assign rvalid0 = w_resp & ~sel_q;
    assign rvalid1 = w_resp &  sel_q;
    assign err0    = w_resp & ~sel_q & w_mis;
    assign err1    = w_resp &  sel_q & w_mis;
    assign rdata0  = (w_resp & ~sel_q) ? rdata_q : '0;
    assign rdata1  = (w_resp &  sel_q) ? rdata_q : '0;
    assign busy    = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_arbiter
//  Purpose  : Self-checking bench for dmem_arbiter with a data_memory model,
//             a reference memory and a response scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0, req1, we0, we1;
    logic [63:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1, busy;
    logic [63:0] rdata0, rdata1;
    logic        mem_read, mem_write;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;

    typedef struct {
        bit          id;
        logic [63:0] rdata;
        bit          err;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [63:0] env_mem [256];
    logic [63:0] ref_mem [256];
    bit          exp_last;
    int          n_checks;
    int          n_errors;
    int          cyc;
    int          gnt_cnt;
    int          wr_cycles;
    int          rv_cyc0;
    int          rv_cyc1;

    dmem_arbiter #(
        .ADDR_W(64),
        .DATA_W(64)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req0     (req0),
        .req1     (req1),
        .we0      (we0),
        .we1      (we1),
        .addr0    (addr0),
        .addr1    (addr1),
        .wdata0   (wdata0),
        .wdata1   (wdata1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .rvalid0  (rvalid0),
        .rvalid1  (rvalid1),
        .rdata0   (rdata0),
        .rdata1   (rdata1),
        .err0     (err0),
        .err1     (err1),
        .busy     (busy),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // data_memory model: combinational read, write on the rising edge.
    assign mem_rdata = mem_read ? env_mem[mem_addr[10:3]] : 64'd0;
    always @(posedge clk) begin
        if (mem_write) env_mem[mem_addr[10:3]] <= mem_wdata;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: compute the expected response in issue order.
    function automatic void sb_push(input bit id, input bit we, input logic [63:0] a,
                                    input logic [63:0] d);
        exp_t e;
        e.id    = id;
        e.err   = (a[2:0] != 3'd0);
        e.rdata = 64'd0;
        if (!e.err) begin
            if (we) ref_mem[a[10:3]] = d;
            else    e.rdata = ref_mem[a[10:3]];
        end
        sb_q.push_back(e);
        exp_last = id;
    endfunction

    task automatic set_req(input bit id, input bit r, input bit we, input logic [63:0] a,
                           input logic [63:0] d);
        if (id) begin
            req1 = r; we1 = we; addr1 = a; wdata1 = d;
        end else begin
            req0 = r; we0 = we; addr0 = a; wdata0 = d;
        end
    endtask

    // Monitor: every rvalid pops the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (gnt0 || gnt1) gnt_cnt++;
            if (mem_write) wr_cycles++;
            if (rvalid0 || rvalid1) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_rvalid", {rvalid1, rvalid0}, 2'b00);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("rvalid_id", {rvalid1, rvalid0}, mon_e.id ? 2'b10 : 2'b01);
                    check("rdata", mon_e.id ? rdata1 : rdata0, mon_e.rdata);
                    check("err", mon_e.id ? err1 : err0, {63'd0, mon_e.err});
                    check("other_side_quiet", mon_e.id ? (rdata0 | {63'd0, err0})
                                                       : (rdata1 | {63'd0, err1}), 64'd0);
                    if (mon_e.id) rv_cyc1 = cyc;
                    else          rv_cyc0 = cyc;
                end
            end
        end
    end

    // One transaction from IDLE; inputs are scrambled right after sampling.
    task automatic txn(input bit id, input bit we, input logic [63:0] a, input logic [63:0] d);
        int  wr0;
        bit  aligned;
        aligned = (a[2:0] == 3'd0);
        wr0     = wr_cycles;
        set_req(id, 1'b1, we, a, d);
        sb_push(id, we, a, d);
        @(posedge clk); #1;
        set_req(id, 1'b0, !we, a + 64'h8, ~d);
        @(negedge clk);
        check("gnt_access", {gnt1, gnt0}, id ? 2'b10 : 2'b01);
        check("mem_read", mem_read, !we && aligned);
        check("mem_write", mem_write, we && aligned);
        check("mem_addr_access", mem_addr, a);
        if (we && aligned) check("mem_wdata", mem_wdata, d);
        @(negedge clk);
        check("gnt_resp", {gnt1, gnt0}, 2'b00);
        check("mem_rw_resp", {mem_read, mem_write}, 2'b00);
        check("mem_addr_resp", mem_addr, a);
        check("busy_resp", busy, 1'b1);
        @(negedge clk);
        check("busy_idle", busy, 1'b0);
        check("rvalid_idle", {rvalid1, rvalid0}, 2'b00);
        check("write_cycles", wr_cycles - wr0, (we && aligned) ? 64'd1 : 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bit first;
        bit w;
        int g0;
        n_checks  = 0;
        n_errors  = 0;
        cyc       = 0;
        gnt_cnt   = 0;
        wr_cycles = 0;
        rv_cyc0   = -100;
        rv_cyc1   = -100;
        exp_last  = 1'b1;
        for (int i = 0; i < 256; i++) begin
            env_mem[i] = 64'hC0DE_0000_0000_0000 | i;
            ref_mem[i] = 64'hC0DE_0000_0000_0000 | i;
        end
        rst_n = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        set_req(1'b1, 1'b0, 1'b0, 64'd0, 64'd0);
        repeat (3) @(negedge clk);
        check("reset_ctrl", {gnt0, gnt1, rvalid0, rvalid1, err0, err1, busy, mem_read, mem_write}, 9'd0);
        check("reset_mem_addr", mem_addr, 64'd0);
        check("reset_mem_wdata", mem_wdata, 64'd0);
        check("reset_rdata", rdata0 | rdata1, 64'd0);

        // Simultaneous first request after reset: 0 then 1.
        rst_n = 1'b1;
        set_req(1'b0, 1'b1, 1'b0, 64'h40, 64'd0);
        set_req(1'b1, 1'b1, 1'b0, 64'h48, 64'd0);
        sb_push(1'b0, 1'b0, 64'h40, 64'd0);
        sb_push(1'b1, 1'b0, 64'h48, 64'd0);
        @(posedge clk); #1;
        req0 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        req1 = 1'b0;
        repeat (3) @(negedge clk);
        check("tie_rvalid_spacing", rv_cyc1 - rv_cyc0, 64'd3);

        // Single write then read.
        txn(1'b0, 1'b1, 64'h10, 64'hABCD);
        txn(1'b0, 1'b0, 64'h10, 64'd0);
        // Misaligned read and write.
        txn(1'b1, 1'b0, 64'h13, 64'd0);
        txn(1'b0, 1'b1, 64'h2D, 64'h77);
        txn(1'b1, 1'b1, 64'h30, 64'h1234_5678_9ABC_DEF0);
        txn(1'b1, 1'b0, 64'h30, 64'd0);
        // Address change mid-transaction (0x18 -> 0x20 by the scramble).
        txn(1'b0, 1'b0, 64'h18, 64'd0);
        // Aliasing above addr[10:3].
        txn(1'b1, 1'b1, 64'h810, 64'hBEEF);
        txn(1'b0, 1'b0, 64'h10, 64'd0);

        // Sustained contention for 12 edges: 4 alternating grants.
        g0 = gnt_cnt;
        set_req(1'b0, 1'b1, 1'b0, 64'h10, 64'd0);
        set_req(1'b1, 1'b1, 1'b0, 64'h30, 64'd0);
        first = !exp_last;
        for (int k = 0; k < 4; k++) begin
            w = first ^ k[0];
            sb_push(w, 1'b0, w ? 64'h30 : 64'h10, 64'd0);
        end
        repeat (12) @(posedge clk);
        #1;
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (4) @(negedge clk);
        check("contention_grants", gnt_cnt - g0, 64'd4);
        check("contention_idle", busy, 1'b0);

        // Reset mid-write: 0x08 holds 0x22, the 0x55 write must be lost.
        txn(1'b0, 1'b1, 64'h08, 64'h22);
        set_req(1'b0, 1'b1, 1'b1, 64'h08, 64'h55);
        @(posedge clk); #1;
        req0 = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_ctrl", {gnt0, gnt1, rvalid0, rvalid1, err0, err1, busy, mem_read, mem_write}, 9'd0);
        exp_last = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        txn(1'b0, 1'b0, 64'h08, 64'd0);

        repeat (4) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
